// File: rtl/tlc5957_pkg.sv
// Shared TLC5957 definitions used by both the chain driver and the frame decoder.
// LAT pulse widths encode the command carried by each 48-bit shift-register word.
package tlc5957_pkg;

  localparam int TLC_WORD_BITS      = 48;
  localparam int TLC_WORDS_PER_LINE = 11;
  localparam int TLC_LATW_BITS      = 4;

  typedef enum logic [TLC_LATW_BITS-1:0] {
    CMD_WRTGS = 4'd1,
    CMD_LATGS = 4'd3
  } lat_cmd_t;

  typedef struct packed {
    logic [TLC_WORD_BITS-1:0] data;
    logic [TLC_LATW_BITS-1:0] latw;
  } tlc_word_t;

endpackage

// File: rtl/tlc5957_frame_decoder_if.sv
// Serial-side inputs and the decoded-word output port of the TLC5957 frame decoder.
// master = the side that drives the serial line and consumes words; slave = the decoder.
interface tlc5957_frame_decoder_if
  import tlc5957_pkg::*;
#(
  parameter int WORD_BITS = TLC_WORD_BITS,
  parameter int LATW_BITS = TLC_LATW_BITS
);
  logic                 sin;
  logic                 shift_en;
  logic                 lat;
  logic [WORD_BITS-1:0] word_data;
  logic [LATW_BITS-1:0] word_latw;
  logic                 word_is_wrtgs;
  logic                 word_is_latgs;
  logic                 word_valid;
  logic                 word_ready;
  logic                 frame_err;
  logic                 seq_err;
  logic                 overflow;
  logic                 line_done;

  modport master (
    output sin, shift_en, lat, word_ready,
    input  word_data, word_latw, word_is_wrtgs, word_is_latgs, word_valid,
           frame_err, seq_err, overflow, line_done
  );

  modport slave (
    input  sin, shift_en, lat, word_ready,
    output word_data, word_latw, word_is_wrtgs, word_is_latgs, word_valid,
           frame_err, seq_err, overflow, line_done
  );
endinterface

// File: rtl/tlc5957_lat_width_counter.sv
// Measures each LAT high pulse and flags the falling edge that closes a word.
// lat_cnt is the width of the pulse that is closing while close is high.
module tlc5957_lat_width_counter
  import tlc5957_pkg::*;
#(
  parameter int LATW_BITS = TLC_LATW_BITS
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 lat,
  output logic [LATW_BITS-1:0] lat_cnt,
  output logic                 close
);
  localparam logic [LATW_BITS-1:0] LATW_SAT = '1;

  logic lat_q;

  assign close = lat_q & ~lat;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      lat_q   <= 1'b0;
      lat_cnt <= '0;
    end else begin
      lat_q <= lat;
      if (close)
        lat_cnt <= '0;
      else if (lat && lat_cnt != LATW_SAT)
        lat_cnt <= lat_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tlc5957_frame_decoder.sv
// Rebuilds 48-bit TLC5957 words from sin/shift_en/lat, classifies them by LAT width
// and checks every line is 10 WRTGS words followed by one LATGS.
module tlc5957_frame_decoder
  import tlc5957_pkg::*;
#(
  parameter int WORD_BITS      = TLC_WORD_BITS,
  parameter int WORDS_PER_LINE = TLC_WORDS_PER_LINE,
  parameter int LATW_BITS      = TLC_LATW_BITS
) (
  input logic                    sclk,
  input logic                    rst_n,
  tlc5957_frame_decoder_if.slave bus
);
  localparam int BCNT_W = 6;
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam logic [BCNT_W-1:0] BCNT_SAT  = '1;
  localparam logic [BCNT_W-1:0] BCNT_WORD = BCNT_W'(WORD_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS_PER_LINE - 1);

  logic [WORD_BITS-1:0] shreg;
  logic [BCNT_W-1:0]    bit_cnt;
  logic [IDX_W-1:0]     word_idx;
  logic [LATW_BITS-1:0] lat_cnt;
  logic                 close;

  logic [WORD_BITS-1:0] out_data;
  logic [LATW_BITS-1:0] out_latw;
  logic                 out_valid, out_ovf, out_ferr, out_serr, out_ldone;

  tlc5957_lat_width_counter #(.LATW_BITS(LATW_BITS)) u_latw (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .lat     (bus.lat),
    .lat_cnt (lat_cnt),
    .close   (close)
  );

  // Close-cycle decisions all use pre-shift state: the bit arriving now belongs to the next word.
  logic good, bad, is_wrtgs, is_latgs, last_slot, seq_adv, seq_line, seq_bad, pop, load;

  always_comb begin
    good      = close && (bit_cnt == BCNT_WORD);
    bad       = close && (bit_cnt != BCNT_WORD);
    is_wrtgs  = (lat_cnt == LATW_BITS'(CMD_WRTGS));
    is_latgs  = (lat_cnt == LATW_BITS'(CMD_LATGS));
    last_slot = (word_idx == IDX_LAST);
    seq_adv   = good && is_wrtgs && !last_slot;
    seq_line  = good && is_latgs && last_slot;
    seq_bad   = good && !seq_adv && !seq_line;
    pop       = out_valid && bus.word_ready;
    load      = good && (!out_valid || bus.word_ready);
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      out_data  <= '0;
      out_latw  <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      out_ferr  <= 1'b0;
      out_serr  <= 1'b0;
      out_ldone <= 1'b0;
    end else begin
      if (bus.shift_en)
        shreg <= {shreg[WORD_BITS-2:0], bus.sin};

      if (close)
        bit_cnt <= bus.shift_en ? BCNT_W'(1) : '0;
      else if (bus.shift_en && bit_cnt != BCNT_SAT)
        bit_cnt <= bit_cnt + 1'b1;

      // Words lost to overflow still advance the line checker.
      if (seq_adv)
        word_idx <= word_idx + 1'b1;
      else if (close)
        word_idx <= '0;

      out_ferr  <= bad;
      out_serr  <= seq_bad;
      out_ldone <= seq_line;

      if (load) begin
        out_data  <= shreg;
        out_latw  <= lat_cnt;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      if (good && !load)
        out_ovf <= 1'b1;
    end
  end

  assign bus.word_data     = out_data;
  assign bus.word_latw     = out_latw;
  assign bus.word_is_wrtgs = (out_latw == LATW_BITS'(CMD_WRTGS));
  assign bus.word_is_latgs = (out_latw == LATW_BITS'(CMD_LATGS));
  assign bus.word_valid    = out_valid;
  assign bus.overflow      = out_ovf;
  assign bus.frame_err     = out_ferr;
  assign bus.seq_err       = out_serr;
  assign bus.line_done     = out_ldone;
endmodule

// File: tb/tb_tlc5957_frame_decoder.sv
// Bench for tlc5957_frame_decoder: word-level reference model (line position,
// single-slot output buffer, sticky overflow) checked every cycle plus scenario checks.
module tb_tlc5957_frame_decoder;
  import tlc5957_pkg::*;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  tlc5957_frame_decoder_if bus();

  tlc5957_frame_decoder dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit        m_valid, m_ovf;
  tlc_word_t m_word;
  int        m_line;
  int        rdy_mode;               // 0 = never ready, 1 = always, 2 = random
  bit        close_due;
  int        c_nbits, c_latw;
  logic [47:0] c_data;
  int        exp_ldone, exp_serr, exp_ferr;
  int        obs_ldone, obs_serr, obs_ferr;

  task automatic model_reset();
    m_valid = 0; m_ovf = 0; m_line = 0; close_due = 0;
    m_word = '0;
  endtask

  // One clock: drive inputs, advance model at word level, compare all outputs after the edge.
  task automatic tick(input logic s, input logic en, input logic l);
    bit do_close, pop, r, e_f, e_s, e_l;
    r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.sin = s; bus.shift_en = en; bus.lat = l; bus.word_ready = r;
    do_close = close_due; close_due = 0;
    pop = m_valid && r;
    e_f = 0; e_s = 0; e_l = 0;
    if (do_close) begin
      if (c_nbits != 48) begin
        e_f = 1; m_line = 0;
      end else begin
        if (c_latw == 1 && m_line < 10) m_line++;
        else if (c_latw == 3 && m_line == 10) begin e_l = 1; m_line = 0; end
        else begin e_s = 1; m_line = 0; end
        if (!m_valid || pop) begin
          m_valid = 1; m_word.data = c_data; m_word.latw = c_latw[3:0];
        end else m_ovf = 1;
      end
    end else if (pop) m_valid = 0;
    exp_ferr += int'(e_f); exp_serr += int'(e_s); exp_ldone += int'(e_l);
    @(posedge sclk); #1;
    obs_ferr += int'(bus.frame_err); obs_serr += int'(bus.seq_err); obs_ldone += int'(bus.line_done);
    n_cmp += 5;
    if (bus.word_valid !== m_valid) begin n_bad++; $display("FAIL word_valid @%0t got %b want %b", $time, bus.word_valid, m_valid); end
    if (bus.overflow !== m_ovf) begin n_bad++; $display("FAIL overflow @%0t got %b want %b", $time, bus.overflow, m_ovf); end
    if (bus.frame_err !== e_f) begin n_bad++; $display("FAIL frame_err @%0t got %b want %b", $time, bus.frame_err, e_f); end
    if (bus.seq_err !== e_s) begin n_bad++; $display("FAIL seq_err @%0t got %b want %b", $time, bus.seq_err, e_s); end
    if (bus.line_done !== e_l) begin n_bad++; $display("FAIL line_done @%0t got %b want %b", $time, bus.line_done, e_l); end
    if (m_valid) begin
      n_cmp += 4;
      if (bus.word_data !== m_word.data) begin n_bad++; $display("FAIL word_data @%0t got %h want %h", $time, bus.word_data, m_word.data); end
      if (bus.word_latw !== m_word.latw) begin n_bad++; $display("FAIL word_latw @%0t got %0d want %0d", $time, bus.word_latw, m_word.latw); end
      if (bus.word_is_wrtgs !== (m_word.latw == 4'd1)) begin n_bad++; $display("FAIL is_wrtgs @%0t got %b latw %0d", $time, bus.word_is_wrtgs, m_word.latw); end
      if (bus.word_is_latgs !== (m_word.latw == 4'd3)) begin n_bad++; $display("FAIL is_latgs @%0t got %b latw %0d", $time, bus.word_is_latgs, m_word.latw); end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  // Bits MSB first; LAT high on the last latw bits; the close happens on the following tick.
  task automatic send_word(input logic [63:0] bits, input int nbits, input int latw, input bit gaps);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (gaps && i >= latw && $urandom_range(0, 3) == 0) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tick(bits[i], 1'b1, 1'(i < latw));
    end
    close_due = 1; c_nbits = nbits; c_latw = (latw > 15) ? 15 : latw; c_data = bits[47:0];
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic send_line(input bit gaps);
    for (int w = 0; w < 10; w++) send_word(rnd64(), 48, 1, gaps);
    send_word(rnd64(), 48, 3, gaps);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.sin = 0; bus.shift_en = 0; bus.lat = 0; bus.word_ready = 0;
    @(posedge sclk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (bus.word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.word_valid); end
    if (bus.word_data !== 48'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", bus.word_data); end
    if (bus.word_latw !== 4'h0) begin n_bad++; $display("FAIL reset_latw got %0d want 0", bus.word_latw); end
    if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    if ({bus.frame_err, bus.seq_err, bus.line_done} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {bus.frame_err, bus.seq_err, bus.line_done}); end
    if ({bus.word_is_wrtgs, bus.word_is_latgs} !== 2'b00) begin n_bad++; $display("FAIL reset_class got %b want 00", {bus.word_is_wrtgs, bus.word_is_latgs}); end
  endtask

  task automatic test_single_word();
    do_reset(); rdy_mode = 1;
    send_word(64'h0000_A5A5_0000_FFFF, 48, 1, 0);
    idle(1);
    n_cmp += 3;
    if (bus.word_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", bus.word_valid); end
    if (bus.word_data !== 48'hA5A5_0000_FFFF) begin n_bad++; $display("FAIL single_data got %h want a5a50000ffff", bus.word_data); end
    if (bus.word_is_wrtgs !== 1'b1) begin n_bad++; $display("FAIL single_wrtgs got %b want 1", bus.word_is_wrtgs); end
    idle(2);
  endtask

  task automatic test_full_line();
    int l0, s0, f0;
    logic [63:0] nxt;
    do_reset(); rdy_mode = 1;
    l0 = obs_ldone; s0 = obs_serr; f0 = obs_ferr;
    send_line(0);
    nxt = rnd64();
    send_word(nxt, 48, 1, 0);   // its first bit shares the LATGS close cycle
    idle(1);
    n_cmp += 4;
    if (obs_ldone - l0 !== 1) begin n_bad++; $display("FAIL line_done_count got %0d want 1", obs_ldone - l0); end
    if (obs_serr - s0 !== 0) begin n_bad++; $display("FAIL line_seq_err got %0d want 0", obs_serr - s0); end
    if (obs_ferr - f0 !== 0) begin n_bad++; $display("FAIL line_frame_err got %0d want 0", obs_ferr - f0); end
    if (bus.word_data !== nxt[47:0]) begin n_bad++; $display("FAIL next_line_word got %h want %h", bus.word_data, nxt[47:0]); end
    idle(2);
  endtask

  task automatic test_frame_err();
    int l0, f0;
    do_reset(); rdy_mode = 1;
    f0 = obs_ferr;
    send_word(rnd64(), 47, 1, 0);
    idle(1);
    send_word(rnd64(), 49, 1, 1);
    idle(1);
    n_cmp += 2;
    if (obs_ferr - f0 !== 2) begin n_bad++; $display("FAIL frame_err_count got %0d want 2", obs_ferr - f0); end
    if (bus.word_valid !== 1'b0) begin n_bad++; $display("FAIL frame_err_valid got %b want 0", bus.word_valid); end
    l0 = obs_ldone;
    send_line(1);
    idle(2);
    n_cmp++;
    if (obs_ldone - l0 !== 1) begin n_bad++; $display("FAIL after_ferr_line got %0d want 1", obs_ldone - l0); end
  endtask

  task automatic test_overflow();
    logic [63:0] w1;
    do_reset(); rdy_mode = 0;
    w1 = rnd64();
    send_word(w1, 48, 1, 0);
    send_word(rnd64(), 48, 1, 0);
    idle(2);
    n_cmp += 2;
    if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    if (bus.word_data !== w1[47:0]) begin n_bad++; $display("FAIL ovf_held got %h want %h", bus.word_data, w1[47:0]); end
    rdy_mode = 1;
    idle(1);
    n_cmp += 2;
    if (bus.word_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_pop got %b want 0", bus.word_valid); end
    if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_early_latgs();
    int l0, s0;
    do_reset(); rdy_mode = 1;
    s0 = obs_serr;
    for (int w = 0; w < 4; w++) send_word(rnd64(), 48, 1, 1);
    send_word(rnd64(), 48, 3, 1);
    idle(1);
    n_cmp += 2;
    if (obs_serr - s0 !== 1) begin n_bad++; $display("FAIL early_latgs_seq got %0d want 1", obs_serr - s0); end
    if (bus.word_is_latgs !== 1'b1) begin n_bad++; $display("FAIL early_latgs_class got %b want 1", bus.word_is_latgs); end
    l0 = obs_ldone;
    send_line(0);
    idle(2);
    n_cmp++;
    if (obs_ldone - l0 !== 1) begin n_bad++; $display("FAIL early_latgs_recover got %0d want 1", obs_ldone - l0); end
  endtask

  task automatic test_lat_saturate();
    int s0;
    do_reset(); rdy_mode = 1;
    s0 = obs_serr;
    for (int w = 0; w < 10; w++) send_word(rnd64(), 48, 1, 0);
    send_word(rnd64(), 48, 16, 0);
    idle(1);
    n_cmp += 3;
    if (bus.word_latw !== 4'd15) begin n_bad++; $display("FAIL latw_sat got %0d want 15", bus.word_latw); end
    if ({bus.word_is_wrtgs, bus.word_is_latgs} !== 2'b00) begin n_bad++; $display("FAIL latw_sat_class got %b want 00", {bus.word_is_wrtgs, bus.word_is_latgs}); end
    if (obs_serr - s0 !== 1) begin n_bad++; $display("FAIL latw_sat_seq got %0d want 1", obs_serr - s0); end
    // WRTGS as the 11th word
    for (int w = 0; w < 11; w++) send_word(rnd64(), 48, 1, 0);
    idle(2);
    n_cmp++;
    if (obs_serr - s0 !== 2) begin n_bad++; $display("FAIL wrtgs_11th got %0d want 2", obs_serr - s0); end
  endtask

  task automatic test_reset_midword();
    logic [63:0] w;
    do_reset(); rdy_mode = 0;
    send_word(rnd64(), 48, 1, 0);
    for (int i = 0; i < 20; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    do_reset();
    n_cmp += 3;
    if (bus.word_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %b want 0", bus.word_valid); end
    if (bus.word_data !== 48'h0) begin n_bad++; $display("FAIL midreset_data got %h want 0", bus.word_data); end
    if ({bus.frame_err, bus.seq_err, bus.line_done, bus.overflow} !== 4'b0) begin n_bad++; $display("FAIL midreset_flags got %b want 0000", {bus.frame_err, bus.seq_err, bus.line_done, bus.overflow}); end
    rdy_mode = 1;
    w = rnd64();
    send_word(w, 48, 1, 1);
    idle(1);
    n_cmp++;
    if (bus.word_data !== w[47:0]) begin n_bad++; $display("FAIL midreset_word got %h want %h", bus.word_data, w[47:0]); end
    idle(2);
  endtask

  task automatic test_random();
    int l0, s0, f0, el0, es0, ef0, nb, lw;
    do_reset(); rdy_mode = 2;
    l0 = obs_ldone; s0 = obs_serr; f0 = obs_ferr;
    el0 = exp_ldone; es0 = exp_serr; ef0 = exp_ferr;
    for (int ln = 0; ln < 8; ln++) begin
      for (int w = 0; w < 11; w++) begin
        nb = 48; lw = (w == 10) ? 3 : 1;
        case ($urandom_range(0, 15))
          0: nb = 47;
          1: nb = 49;
          2: lw = $urandom_range(1, 17);
          default: ;
        endcase
        send_word(rnd64(), nb, lw, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    n_cmp += 3;
    if (obs_ldone - l0 !== exp_ldone - el0) begin n_bad++; $display("FAIL rand_line_done got %0d want %0d", obs_ldone - l0, exp_ldone - el0); end
    if (obs_serr - s0 !== exp_serr - es0) begin n_bad++; $display("FAIL rand_seq_err got %0d want %0d", obs_serr - s0, exp_serr - es0); end
    if (obs_ferr - f0 !== exp_ferr - ef0) begin n_bad++; $display("FAIL rand_frame_err got %0d want %0d", obs_ferr - f0, exp_ferr - ef0); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sin = 0; bus.shift_en = 0; bus.lat = 0; bus.word_ready = 0;
    exp_ldone = 0; exp_serr = 0; exp_ferr = 0;
    obs_ldone = 0; obs_serr = 0; obs_ferr = 0;
    rdy_mode = 1;
    model_reset();
    test_reset();
    test_single_word();
    test_full_line();
    test_frame_err();
    test_overflow();
    test_early_latgs();
    test_lat_saturate();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlc5957_frame_decoder.md
Name: tlc5957_frame_decoder

Overview:
- Protocol-side receiver for the TLC5957 serial chain. It watches a serial data line, a bit-valid strobe and LAT, and rebuilds 48-bit shift-register words.
- Each word is classified by its LAT pulse width: 1 cycle = WRTGS, 3 cycles = LATGS, any other width = other command.
- Each line is checked for 10 WRTGS words followed by 1 LATGS.
- Used for chain-return loopback (SOUT of the last driver) and as a bench/in-system monitor on the driver's sout/lat.

Parameters:
- WORD_BITS, 48, bits per TLC5957 word.
- WORDS_PER_LINE, 11, words per line; the last one is LATGS.
- LATW_BITS, 4, width of the LAT pulse-width counter (saturating).

Ports:
- sclk  in  1  serial clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- sin  in  1  serial data, MSB first (bit 47 first).
- shift_en  in  1  sin carries a valid bit this cycle.
- lat  in  1  LAT as driven alongside the data bits.
- word_data  out  48  captured word, bit 47 = first bit received.
- word_latw  out  4  LAT high-cycle count for the word (saturates at 15).
- word_is_wrtgs  out  1  word_latw == 1.
- word_is_latgs  out  1  word_latw == 3.
- word_valid  out  1  output register holds a word.
- word_ready  in  1  consumer accepts the word when valid && ready.
- frame_err  out  1  one-cycle pulse: LAT fell with bit count != WORD_BITS.
- seq_err  out  1  one-cycle pulse: line sequence violated.
- overflow  out  1  sticky: a good word was dropped because the output was full.
- line_done  out  1  one-cycle pulse: a LATGS word closed a correct line.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; shift register, bit_cnt, lat_cnt, word_idx and lat_q are 0.
- Shift: each cycle with shift_en=1, shreg <= {shreg[46:0], sin}. bit_cnt increments and saturates at 63.
- LAT width: while lat=1, lat_cnt increments and saturates at 15. lat_q holds the previous lat.
- Word close happens in the cycle where lat_q=1 and lat=0:
  - The candidate word is shreg as it was before this cycle's shift. A bit shifted in this same cycle belongs to the next word, so bit_cnt <= shift_en ? 1 : 0.
  - The candidate width is lat_cnt; then lat_cnt <= 0.
  - If bit_cnt != 48: pulse frame_err, discard the word, reset word_idx to 0, no sequence check.
- Output handshake (single register, latency 1 cycle after the close cycle):
  - Load the register if word_valid=0, or if word_valid && word_ready in the same cycle (pop and push together).
  - Otherwise drop the word and set overflow; it stays set until reset.
  - word_valid clears on valid && ready when no new word loads.
- Sequence checker: runs on every good word (bit_cnt == 48), including words dropped by overflow.
  - WRTGS with word_idx < 10: word_idx++.
  - LATGS with word_idx == 10: pulse line_done, word_idx <= 0.
  - Any other case (LATGS early, WRTGS as the 11th word, other width): pulse seq_err, word_idx <= 0.
- Edge cases:
  - LAT rising mid-word does not affect shifting.
  - LAT high for more than 15 cycles saturates word_latw at 15, which is classified as other.
  - shift_en=0 cycles inside a word are gaps; bits need not be back-to-back.
  - More than 48 bits before LAT falls: shreg keeps the last 48 bits, bit_cnt != 48, so frame_err.
- Reset mid-word discards partial state. The next word starts counting from the first shift_en after reset.
- frame_err, seq_err and line_done are registered pulses aligned with word_valid's load cycle.

Decomposition:
- Shared package tlc5957_pkg holds:
  - TLC_WORD_BITS=48, TLC_WORDS_PER_LINE=11.
  - Enum lat_cmd_t {CMD_WRTGS=1, CMD_LATGS=3}.
  - The word record typedef (data, latw).
- The driver and this decoder share the package.
- One sub-module, tlc5957_lat_width_counter: lat edge detect, saturating counter, close strobe.

Test Plan:
- Word 48'hA5A5_0000_FFFF, 48 shift_en bits MSB first, lat high on the last bit only, ready=1 -> word_valid 1 cycle after lat falls; word_data=48'hA5A5_0000_FFFF, word_latw=1, word_is_wrtgs=1.
- Full line of 10 WRTGS words (lat 1 cycle) then 1 LATGS word (lat on the last 3 bits), back-to-back bits -> 11 words out, line_done pulses once, no seq_err/frame_err; the first bit of the next line is not lost.
- 47 bits then lat for 1 cycle -> frame_err pulse, no word_valid, word_idx reset; the next good line produces line_done.
- ready=0, two good WRTGS words -> the first is held, overflow=1 after the second, word_data still holds the first; ready=1 pops the first word, overflow stays 1.
- LATGS as the 5th word -> seq_err pulse, word still output with word_is_latgs=1; the next 10 WRTGS + 1 LATGS -> line_done.
- rst_n low for 1 cycle after bit 20 of a word -> all outputs 0; a subsequent clean 48-bit word decodes correctly.
